// File: rtl/spi_param_fifo_pkg.sv
// Shared types and defaults for the parametrised SPI data-path FIFO.
// Optional build macro: SPI_FIFO_FWFT_EN (first-word fall-through read).
package spi_param_fifo_pkg;

    localparam int SPI_FIFO_IRQ_W  = 5;
    localparam int SPI_FIFO_DEPTH  = 16;
    localparam int SPI_FIFO_DATA_W = 32;

    // Bit order matches the irq_en / irq_clr / irq_stat port layout.
    typedef struct packed {
        logic ovf;
        logic udf;
        logic af;
        logic ae;
        logic full;
    } fifo_irq_t;

endpackage

// File: rtl/spi_fifo_ram.sv
// Simple dual-port FIFO storage: synchronous write, registered read port,
// or a combinational read port when SPI_FIFO_FWFT_EN is defined.
module spi_fifo_ram
    import spi_param_fifo_pkg::*;
#(
    parameter int DATA_W = SPI_FIFO_DATA_W,
    parameter int DEPTH  = SPI_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
`ifndef SPI_FIFO_FWFT_EN
    input  logic              rst,
    input  logic              re,
`endif
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SPI_FIFO_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Reads the pre-edge contents, so a same-slot write when full is safe.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/spi_param_fifo.sv
// Parametrised SPI TX/RX FIFO with level, watermarks and sticky maskable IRQs.
// Optional build macro: SPI_FIFO_FWFT_EN (first-word fall-through read).
module spi_param_fifo
    import spi_param_fifo_pkg::*;
#(
    parameter int DATA_W = SPI_FIFO_DATA_W,
    parameter int DEPTH  = SPI_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      store,
    input  logic                      load,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_valid,
    output logic [AW:0]               level,
    output logic                      full,
    output logic                      empty,
    input  logic [AW:0]               af_thr,
    input  logic [AW:0]               ae_thr,
    output logic                      almost_full,
    output logic                      almost_empty,
    input  logic [SPI_FIFO_IRQ_W-1:0] irq_en,
    input  logic [SPI_FIFO_IRQ_W-1:0] irq_clr,
    output logic [SPI_FIFO_IRQ_W-1:0] irq_stat,
    output logic                      irq
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    fifo_irq_t         irq_stat_q, irq_stat_d;
    fifo_irq_t         irq_set;
    logic [2:0]        flg_q, flg_d;     // previous {af, ae, full} for edge detect
    logic [2:0]        flg_idle;         // flag values at level 0
    logic [AW:0]       level_w;
    logic              full_w, empty_w, af_w, ae_w;
    logic              do_wr, do_rd, ovf_ev, udf_ev;
    logic [DATA_W-1:0] ram_rdata;

    assign level_w  = wr_ptr_q - rd_ptr_q;
    assign full_w   = (level_w == LVL_FULL);
    assign empty_w  = (level_w == '0);
    assign af_w     = (level_w >= af_thr);
    assign ae_w     = (level_w <= ae_thr);
    assign flg_idle = {(af_thr == '0), 1'b1, 1'b0};

    // A load frees a slot, so a store while full still lands if paired with one.
    assign do_rd  = load && !empty_w;
    assign do_wr  = store && (!full_w || load);
    assign ovf_ev = store && full_w && !load;
    assign udf_ev = load && empty_w;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        flg_d        = {af_w, ae_w, full_w};
        irq_set      = '0;
        irq_set.ovf  = ovf_ev;
        irq_set.udf  = udf_ev;
        irq_set.af   = af_w   && !flg_q[2];
        irq_set.ae   = ae_w   && !flg_q[1];
        irq_set.full = full_w && !flg_q[0];
        // Set beats clear on the same bit.
        irq_stat_d   = (irq_stat_q & ~fifo_irq_t'(irq_clr)) | irq_set;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            irq_stat_d = '0;
            flg_d      = flg_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            irq_stat_q <= '0;
            flg_q      <= flg_idle;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            irq_stat_q <= irq_stat_d;
            flg_q      <= flg_d;
        end
    end

    spi_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
`ifndef SPI_FIFO_FWFT_EN
        .rst   (rst),
        .re    (do_rd && !clear),
`endif
        .we    (do_wr && !clear),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

`ifdef SPI_FIFO_FWFT_EN
    // Head word is visible whenever the FIFO holds data.
    assign data_out = empty_w ? '0 : ram_rdata;
    assign rd_valid = !empty_w;
`else
    logic rd_valid_q, rd_valid_d;

    always_comb begin
        rd_valid_d = do_rd;
        if (clear) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = ram_rdata;
    assign rd_valid = rd_valid_q;
`endif

    assign level        = level_w;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = af_w;
    assign almost_empty = ae_w;
    assign irq_stat     = irq_stat_q;
    assign irq          = |(irq_stat_q & irq_en);

endmodule

// File: tb/tb_spi_param_fifo.sv
// Self-checking bench for spi_param_fifo (registered-read build): queue
// scoreboard for data order, threshold vector table, hand-written corners.
module tb_spi_param_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst, clear, store, load;
    logic [DATA_W-1:0] data_in, data_out;
    logic              rd_valid;
    logic [AW:0]       level, af_thr, ae_thr;
    logic              full, empty, almost_full, almost_empty;
    logic [4:0]        irq_en, irq_clr, irq_stat;
    logic              irq;

    always #5 clk = ~clk;

    spi_param_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .store(store), .load(load),
        .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
        .level(level), .full(full), .empty(empty),
        .af_thr(af_thr), .ae_thr(ae_thr),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .irq_en(irq_en), .irq_clr(irq_clr), .irq_stat(irq_stat), .irq(irq)
    );

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] mdl[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_rd = '0;

    typedef struct {
        logic [AW:0] af;
        logic [AW:0] ae;
        logic        exp_af;
        logic        exp_ae;
    } thr_vec_t;
    thr_vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of store/load traffic against the queue model.
    task automatic cycle(input logic st, input logic ld, input logic [DATA_W-1:0] din);
        logic rd_ok, wr_ok;
        rd_ok = ld && (mdl.size() > 0);
        wr_ok = st && ((mdl.size() < DEPTH) || ld);
        if (rd_ok) exp_q.push_back(mdl.pop_front());
        if (wr_ok) mdl.push_back(din);
        store = st; load = ld; data_in = din;
        tick();
        store = 1'b0; load = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(rd_ok));
        if (rd_ok) begin
            last_rd = exp_q.pop_front();
            chk("data_out", data_out, last_rd);
        end
        chk("level", 32'(level), 32'(mdl.size()));
    endtask

    initial begin
        tv[0] = '{5'd8,  5'd2,  1'b1, 1'b0};
        tv[1] = '{5'd9,  5'd2,  1'b0, 1'b0};
        tv[2] = '{5'd0,  5'd0,  1'b1, 1'b0};
        tv[3] = '{5'd16, 5'd8,  1'b0, 1'b1};
        tv[4] = '{5'd12, 5'd7,  1'b0, 1'b0};
        tv[5] = '{5'd5,  5'd16, 1'b1, 1'b1};

        rst = 1'b1; clear = 1'b0; store = 1'b0; load = 1'b0; data_in = '0;
        af_thr = 5'd12; ae_thr = 5'd2; irq_en = 5'h1F; irq_clr = 5'h00;
        tick(); tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_irq_stat", 32'(irq_stat), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_irq_stat", 32'(irq_stat), 0);

        // Fill to full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h27 + 32'(i));
        chk("fill_full", 32'(full), 1);
        cycle(1'b0, 1'b0, '0);
        chk("fill_irq_stat", 32'(irq_stat), 32'h05);
        chk("fill_irq", 32'(irq), 1);
        chk("fill_af", 32'(almost_full), 1);

        // Overflow drops the word.
        cycle(1'b1, 1'b0, 32'hAA);
        chk("ovf_irq_stat", 32'(irq_stat), 32'h15);

        // Drain; scoreboard checks 0x27..0x36 with no 0xAA.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_irq_stat", 32'(irq_stat), 32'h17);

        // Underflow and write-1-to-clear.
        cycle(1'b0, 1'b1, '0);
        chk("udf_data_hold", data_out, 32'h36);
        chk("udf_irq_stat", 32'(irq_stat), 32'h1F);
        irq_clr = 5'b01000;
        cycle(1'b0, 1'b0, '0);
        chk("udf_cleared", 32'(irq_stat), 32'h17);
        cycle(1'b0, 1'b1, '0);
        chk("udf_set_wins", 32'(irq_stat), 32'h1F);
        irq_clr = 5'h1F;
        cycle(1'b0, 1'b0, '0);
        irq_clr = 5'h00;
        chk("clr_all", 32'(irq_stat), 0);
        chk("clr_all_irq", 32'(irq), 0);
        cycle(1'b0, 1'b1, '0);
        irq_en = 5'b10111;
        #1;
        chk("irq_masked", 32'(irq), 0);
        irq_en = 5'h1F;
        #1;
        chk("irq_unmasked", 32'(irq), 1);
        irq_clr = 5'h1F;
        cycle(1'b0, 1'b0, '0);
        irq_clr = 5'h00;

        // Level 8, then streaming store+load across the pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 32'h200 + 32'(i));

        // Watermark table at level 8 (no clock edge inside the loop).
        for (int i = 0; i < 6; i++) begin
            af_thr = tv[i].af; ae_thr = tv[i].ae;
            #1;
            chk($sformatf("thr%0d_af", i), 32'(almost_full), 32'(tv[i].exp_af));
            chk($sformatf("thr%0d_ae", i), 32'(almost_empty), 32'(tv[i].exp_ae));
        end
        af_thr = 5'd12; ae_thr = 5'd2;

        // Full with simultaneous store+load: no overflow.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h300 + 32'(i));
        cycle(1'b0, 1'b0, '0);
        irq_clr = 5'h1F;
        cycle(1'b0, 1'b0, '0);
        irq_clr = 5'h00;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h400 + 32'(i));
        chk("full_rw_full", 32'(full), 1);
        chk("full_rw_no_ovf", 32'(irq_stat), 0);
        cycle(1'b1, 1'b0, 32'hBB);
        chk("ovf_again", 32'(irq_stat), 32'h10);

        // Clear at level 10 together with a store.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);
        clear = 1'b1; store = 1'b1; data_in = 32'h99;
        tick();
        clear = 1'b0; store = 1'b0;
        mdl.delete();
        chk("clr_level", 32'(level), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_irq_stat", 32'(irq_stat), 0);
        chk("clr_rd_valid", 32'(rd_valid), 0);
        chk("clr_data_hold", data_out, last_rd);
        cycle(1'b0, 1'b0, '0);
        chk("clr_irq_quiet", 32'(irq_stat), 0);

        // Reset mid-stream.
        cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h500 + 32'(i));
        cycle(1'b0, 1'b1, '0);
        rst = 1'b1; store = 1'b1; data_in = 32'h77;
        tick();
        rst = 1'b0; store = 1'b0;
        mdl.delete(); exp_q.delete();
        chk("mrst_level", 32'(level), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_data_out", data_out, 0);
        chk("mrst_rd_valid", 32'(rd_valid), 0);
        chk("mrst_irq_stat", 32'(irq_stat), 0);

        cycle(1'b1, 1'b0, 32'h5A);
        cycle(1'b0, 1'b1, '0);
        chk("final_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
